// File: rtl/mem_port_arbiter.sv
// Two-master req/gnt/ack arbiter in front of a single-port synchronous RAM.
// Round-robin by default; define ARB_FIXED_PRIO_EN to make req0 always win ties.
module mem_port_arbiter #(
  parameter int AW      = 9,
  parameter int DW      = 9,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int CW = $clog2(MEM_LAT + 2);

  // state  | meaning
  // IDLE   | no access; arbitrates on every edge with a request pending
  // ACCESS | RAM cycle in progress, lasts MEM_LAT+1 cycles
  // ACK    | one-cycle ack pulse; grant still held, no arbitration
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          sel, sel_d;
  logic          we_q, we_q_d;
  logic          win;
  logic          gnt0_d, gnt1_d, ack0_d, ack1_d, mem_we_d;
  logic [DW-1:0] rdata_d, wdata_d;
  logic [AW-1:0] addr_d;

`ifdef ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  logic prio1;  // 1: requester 1 wins the next tie

  assign win = req1 & (~req0 | prio1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      prio1 <= 1'b0;
    else if (state == IDLE && (req0 || req1))
      prio1 <= ~win;
  end
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sel_d    = sel;
    we_q_d   = we_q;
    gnt0_d   = gnt0;
    gnt1_d   = gnt1;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    mem_we_d = 1'b0;
    rdata_d  = rdata;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d  = ACCESS;
          cnt_d    = CW'(MEM_LAT);
          sel_d    = win;
          we_q_d   = win ? we1 : we0;
          mem_we_d = win ? we1 : we0;
          gnt0_d   = ~win;
          gnt1_d   = win;
          addr_d   = win ? addr1 : addr0;
          wdata_d  = win ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_d = ACK;
          ack0_d  = ~sel;
          ack1_d  = sel;
          if (!we_q)
            rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      we_q      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sel       <= sel_d;
      we_q      <= we_q_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      mem_we    <= mem_we_d;
      rdata     <= rdata_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end
endmodule
